// File: rtl/qar_gpio_seq_pkg.sv
// Shared definitions for the GPIO block and the GPIO step sequencer:
// register word offsets, sequencer config map and FSM encoding.
package qar_gpio_seq_pkg;

    localparam logic [2:0] GPIO_DIR     = 3'd0;
    localparam logic [2:0] GPIO_OUT     = 3'd1;
    localparam logic [2:0] GPIO_IN      = 3'd2;
    localparam logic [2:0] GPIO_OUT_SET = 3'd3;
    localparam logic [2:0] GPIO_OUT_CLR = 3'd4;

    localparam logic [4:0] CFG_CTRL   = 5'd0;
    localparam logic [4:0] CFG_STATUS = 5'd1;
    localparam logic [4:0] CFG_SEL    = 5'd2;
    localparam logic [4:0] CFG_OP     = 5'd3;
    localparam logic [4:0] CFG_DATA   = 5'd4;
    localparam logic [4:0] CFG_DELAY  = 5'd5;
    localparam logic [4:0] CFG_LEN    = 5'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        TF_OP   = 2'd0,
        TF_DATA = 2'd1,
        TF_DLY  = 2'd2
    } tbl_field_e;

    // IN is read-only, so a step may only target DIR/OUT/SET/CLR
    function automatic logic op_valid(input logic [31:0] v);
        return v == 32'(GPIO_DIR)
            || v == 32'(GPIO_OUT)
            || v == 32'(GPIO_OUT_SET)
            || v == 32'(GPIO_OUT_CLR);
    endfunction

endpackage

// File: rtl/qar_gpio_seq_table.sv
// Step table: STEPS x {op, data, delay}, one write port,
// one async read port for config and one for the sequencer.
module qar_gpio_seq_table
    import qar_gpio_seq_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int WIDTH = 32,
    parameter int IW    = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             we,
    input  tbl_field_e       wfield,
    input  logic [IW-1:0]    waddr,
    input  logic [31:0]      wdata,
    input  logic [IW-1:0]    ca_addr,
    output logic [2:0]       ca_op,
    output logic [WIDTH-1:0] ca_data,
    output logic [15:0]      ca_dly,
    input  logic [IW-1:0]    sq_addr,
    output logic [2:0]       sq_op,
    output logic [WIDTH-1:0] sq_data,
    output logic [15:0]      sq_dly
);

    logic [2:0]       op_mem   [STEPS];
    logic [WIDTH-1:0] data_mem [STEPS];
    logic [15:0]      dly_mem  [STEPS];

    // Contents survive reset so a program can be rerun after an abort
    always_ff @(posedge clk) begin
        if (we) begin
            unique case (wfield)
                TF_OP:   op_mem[waddr]   <= wdata[2:0];
                TF_DATA: data_mem[waddr] <= wdata[WIDTH-1:0];
                TF_DLY:  dly_mem[waddr]  <= wdata[15:0];
                default: ;
            endcase
        end
    end

    assign ca_op   = op_mem[ca_addr];
    assign ca_data = data_mem[ca_addr];
    assign ca_dly  = dly_mem[ca_addr];
    assign sq_op   = op_mem[sq_addr];
    assign sq_data = data_mem[sq_addr];
    assign sq_dly  = dly_mem[sq_addr];

endmodule

// File: rtl/qar_gpio_seq.sv
// GPIO step sequencer: replays a table of GPIO register writes
// with per-step delays through a shared, granted register port.
module qar_gpio_seq
    import qar_gpio_seq_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic        cfg_re,
    input  logic [4:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        gpio_req,
    input  logic        gpio_gnt,
    output logic        gpio_we,
    output logic [4:0]  gpio_addr,
    output logic [31:0] gpio_wdata,
    output logic        busy,
    output logic        done
);

    localparam int IW = $clog2(STEPS);
    localparam int LW = IW + 1;

    seq_state_e       state_q, state_d;
    logic [IW-1:0]    step_q, step_d;
    logic [15:0]      loop_q, loop_d;
    logic [15:0]      dcnt_q, dcnt_d;
    logic             done_q, done_d;
    logic             loop_en_q;
    logic [IW-1:0]    sel_q;
    logic [LW-1:0]    len_q;
    logic             advance;
    logic             last;

    logic             wr_ctrl, start_cmd, stop_cmd, running, issue;
    logic             tbl_we;
    tbl_field_e       tbl_field;
    logic [2:0]       ca_op, sq_op;
    logic [WIDTH-1:0] ca_data, sq_data;
    logic [15:0]      ca_dly, sq_dly;

    assign wr_ctrl   = cfg_we && (cfg_addr == CFG_CTRL);
    assign stop_cmd  = wr_ctrl && cfg_wdata[1];
    assign start_cmd = wr_ctrl && cfg_wdata[0] && !cfg_wdata[1];
    assign running   = (state_q != S_IDLE);
    assign last      = (({1'b0, step_q} + LW'(1)) == len_q);

    assign tbl_we = cfg_we && !running && (
        (cfg_addr == CFG_OP && op_valid(cfg_wdata))
        || cfg_addr == CFG_DATA
        || cfg_addr == CFG_DELAY);

    assign tbl_field = (cfg_addr == CFG_OP)   ? TF_OP :
                       (cfg_addr == CFG_DATA) ? TF_DATA : TF_DLY;

    qar_gpio_seq_table #(
        .STEPS (STEPS),
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_table (
        .clk     (clk),
        .we      (tbl_we),
        .wfield  (tbl_field),
        .waddr   (sel_q),
        .wdata   (cfg_wdata),
        .ca_addr (sel_q),
        .ca_op   (ca_op),
        .ca_data (ca_data),
        .ca_dly  (ca_dly),
        .sq_addr (step_q),
        .sq_op   (sq_op),
        .sq_data (sq_data),
        .sq_dly  (sq_dly)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            loop_q    <= '0;
            dcnt_q    <= '0;
            done_q    <= 1'b0;
            loop_en_q <= 1'b0;
            sel_q     <= '0;
            len_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            loop_q  <= loop_d;
            dcnt_q  <= dcnt_d;
            done_q  <= done_d;
            if (wr_ctrl)
                loop_en_q <= cfg_wdata[2];
            if (cfg_we && cfg_addr == CFG_SEL)
                sel_q <= cfg_wdata[IW-1:0];
            if (cfg_we && cfg_addr == CFG_LEN && !running
                && cfg_wdata <= 32'(STEPS))
                len_q <= cfg_wdata[LW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        loop_d  = loop_q;
        dcnt_d  = dcnt_q;
        done_d  = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_cmd && len_q != '0) begin
                    state_d = S_ISSUE;
                    step_d  = '0;
                    loop_d  = '0;
                end
            end
            S_ISSUE: begin
                if (gpio_gnt) begin
                    if (sq_dly != 16'd0) begin
                        state_d = S_WAIT;
                        dcnt_d  = sq_dly - 16'd1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (dcnt_q == 16'd0)
                    advance = 1'b1;
                else
                    dcnt_d = dcnt_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            state_d = S_ISSUE;
            if (!last) begin
                step_d = step_q + IW'(1);
            end else if (loop_en_q) begin
                step_d = '0;
                if (loop_q != 16'hFFFF)
                    loop_d = loop_q + 16'd1;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
        // An abort never reports completion
        if (stop_cmd) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    assign issue      = (state_q == S_ISSUE) && !rst;
    assign gpio_req   = issue;
    assign gpio_we    = issue && gpio_gnt && !stop_cmd;
    assign gpio_addr  = issue ? {2'b00, sq_op} : 5'd0;
    assign gpio_wdata = issue ? 32'(sq_data) : 32'd0;
    assign busy       = running && !rst;
    assign done       = done_q && !rst;

    always_comb begin
        cfg_rdata = 32'd0;
        if (cfg_re) begin
            unique case (cfg_addr)
                CFG_CTRL:   cfg_rdata = {29'd0, loop_en_q, 2'b00};
                CFG_STATUS: cfg_rdata = {loop_q, 8'h00, 4'(step_q),
                                         3'b000, busy};
                CFG_SEL:    cfg_rdata = 32'(sel_q);
                CFG_OP:     cfg_rdata = {29'd0, ca_op};
                CFG_DATA:   cfg_rdata = 32'(ca_data);
                CFG_DELAY:  cfg_rdata = {16'd0, ca_dly};
                CFG_LEN:    cfg_rdata = 32'(len_q);
                default:    cfg_rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_qar_gpio_seq.sv
// Self-checking bench for qar_gpio_seq: cycle vectors, corner
// sequences and randomized programs against a timing model.
`timescale 1ns/1ps
module tb_qar_gpio_seq;
    import qar_gpio_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, cfg_we, cfg_re;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic        gpio_req, gpio_gnt, gpio_we;
    logic [4:0]  gpio_addr;
    logic [31:0] gpio_wdata;
    logic        busy, done;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    qar_gpio_seq #(.STEPS(8), .WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_re     (cfg_re),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .gpio_req   (gpio_req),
        .gpio_gnt   (gpio_gnt),
        .gpio_we    (gpio_we),
        .gpio_addr  (gpio_addr),
        .gpio_wdata (gpio_wdata),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        bit          start;
        bit          gnt;
        bit          req;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        bit          busy_x;
        bit          busy;
        bit          done;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit s, bit g, bit r, bit w,
                                logic [4:0] a, logic [31:0] d,
                                bit bx, bit b, bit dn);
        vec_t x;
        x.start = s; x.gnt = g; x.req = r; x.we = w;
        x.addr = a; x.wdata = d; x.busy_x = bx;
        x.busy = b; x.done = dn;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
        cfg_re = 1'b1; cfg_addr = a;
        #1;
        d = cfg_rdata;
        cfg_re = 1'b0; cfg_addr = '0;
    endtask

    task automatic prog(input int idx, input logic [31:0] op,
                        input logic [31:0] data, input logic [31:0] dly);
        cfg_write(CFG_SEL, 32'(idx));
        cfg_write(CFG_OP, op);
        cfg_write(CFG_DATA, data);
        cfg_write(CFG_DELAY, dly);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"},   gpio_req,   0);
        check({tag, "_we"},    gpio_we,    0);
        check({tag, "_addr"},  gpio_addr,  0);
        check({tag, "_wdata"}, gpio_wdata, 0);
        check({tag, "_busy"},  busy,       0);
        check({tag, "_done"},  done,       0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] rd;
    logic [2:0]  vops [4];
    logic [2:0]  r_op [4];
    logic [31:0] r_dat [4];
    int          r_dly [4];
    int          r_ec [4];
    bit          gp [200];
    int          nw, lastc, len, t, done_c, stray;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; gpio_gnt = 1'b0;
        vops[0] = GPIO_DIR; vops[1] = GPIO_OUT;
        vops[2] = GPIO_OUT_SET; vops[3] = GPIO_OUT_CLR;
        tick(); tick();
        check_quiet("in_reset");
        rst = 1'b0;
        #1;
        check_quiet("after_reset");
        cfg_read(CFG_CTRL, rd);   check("rst_ctrl", rd, 0);
        cfg_read(CFG_STATUS, rd); check("rst_status", rd, 0);
        cfg_read(CFG_SEL, rd);    check("rst_sel", rd, 0);
        cfg_read(CFG_LEN, rd);    check("rst_len", rd, 0);

        // Two-step program, first always granted, then grant held off
        prog(0, GPIO_OUT_SET, 32'h1, 3);
        prog(1, GPIO_OUT_CLR, 32'h1, 0);
        cfg_write(CFG_LEN, 2);
        cfg_addr = CFG_SEL; cfg_wdata = 5;
        #1;
        check("rdata_no_re", cfg_rdata, 0);
        cfg_read(5'd9, rd); check("rdata_unmapped", rd, 0);

        vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 3, 1, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 1, 1, 1, 4, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1));
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(0, 0, 1, 0, 3, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 1, 1, 3, 1, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 1, 1, 1, 4, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1));
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            cfg_we    = vt[i].start;
            cfg_addr  = vt[i].start ? CFG_CTRL : 5'd0;
            cfg_wdata = vt[i].start ? 32'h1 : 32'h0;
            gpio_gnt  = vt[i].gnt;
            #1;
            check($sformatf("vec%0d_req", i),   gpio_req,   vt[i].req);
            check($sformatf("vec%0d_we", i),    gpio_we,    vt[i].we);
            check($sformatf("vec%0d_addr", i),  gpio_addr,  vt[i].addr);
            check($sformatf("vec%0d_wdata", i), gpio_wdata, vt[i].wdata);
            if (!vt[i].busy_x)
                check($sformatf("vec%0d_busy", i), busy, vt[i].busy);
            check($sformatf("vec%0d_done", i),  done,       vt[i].done);
            tick();
        end
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        // Looping single step, then STOP on a grant cycle
        prog(0, GPIO_OUT, 32'hA5, 1);
        cfg_write(CFG_LEN, 1);
        gpio_gnt = 1'b1;
        cfg_write(CFG_CTRL, 32'h5);
        nw = 0; lastc = 0;
        for (int c = 1; c <= 40 && nw < 4; c++) begin
            if (gpio_we) begin
                nw++;
                if (nw > 1) check("loop_gap", c - lastc, 2);
                lastc = c;
                check("loop_addr", gpio_addr, 1);
                check("loop_wdata", gpio_wdata, 32'hA5);
            end
            if (nw < 4) tick();
        end
        check("loop_writes", nw, 4);
        cfg_read(CFG_STATUS, rd);
        check("loop_count", rd[31:16], 3);
        check("loop_status_busy", rd[0], 1);
        tick(); tick();
        cfg_we = 1'b1; cfg_addr = CFG_CTRL; cfg_wdata = 32'h2;
        #1;
        check("stop_gnt_req", gpio_req, 1);
        check("stop_gnt_we", gpio_we, 0);
        tick();
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        tick();
        check("stop_done2", done, 0);

        // Rejected starts and writes while busy
        cfg_write(CFG_LEN, 0);
        cfg_write(CFG_CTRL, 32'h1);
        check("len0_busy", busy, 0);
        prog(0, GPIO_OUT_SET, 32'h77, 40);
        cfg_write(CFG_OP, 32'h2);
        cfg_read(CFG_OP, rd); check("bad_op_ignored", rd, 3);
        cfg_write(CFG_LEN, 1);
        cfg_write(CFG_CTRL, 32'h3);
        check("start_stop_busy", busy, 0);
        cfg_write(CFG_CTRL, 32'h1);
        tick();
        check("long_wait_busy", busy, 1);
        cfg_write(CFG_SEL, 0);
        cfg_write(CFG_DATA, 32'hDEAD);
        cfg_write(CFG_OP, GPIO_DIR);
        cfg_write(CFG_LEN, 3);
        cfg_write(CFG_CTRL, 32'h2);
        check("abort_busy", busy, 0);
        cfg_read(CFG_DATA, rd); check("busy_data_kept", rd, 32'h77);
        cfg_read(CFG_OP, rd);   check("busy_op_kept", rd, 3);
        cfg_read(CFG_LEN, rd);  check("busy_len_kept", rd, 1);

        // Reset while waiting, then rerun from the retained table
        prog(0, GPIO_OUT, 32'h3C, 5);
        prog(1, GPIO_OUT_SET, 32'h40, 0);
        cfg_write(CFG_LEN, 2);
        gpio_gnt = 1'b1;
        cfg_write(CFG_CTRL, 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_quiet("rst_wait");
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            if (gpio_we) stray++;
            tick();
        end
        check("rst_no_write", stray, 0);
        cfg_read(CFG_LEN, rd);    check("rst_len_cleared", rd, 0);
        cfg_read(CFG_STATUS, rd); check("rst_status_idle", rd, 0);
        cfg_read(CFG_OP, rd);     check("rst_table_kept", rd, 1);
        cfg_write(CFG_LEN, 2);
        cfg_write(CFG_CTRL, 32'h1);
        check("rerun_we0", gpio_we, 1);
        check("rerun_addr0", gpio_addr, 1);
        check("rerun_data0", gpio_wdata, 32'h3C);
        for (int i = 0; i < 6; i++) tick();
        check("rerun_we1", gpio_we, 1);
        check("rerun_addr1", gpio_addr, 3);
        check("rerun_data1", gpio_wdata, 32'h40);
        tick();
        check("rerun_done", done, 1);

        // Random programs and grant patterns against a timing model
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                r_op[k]  = vops[$urandom_range(0, 3)];
                r_dat[k] = $urandom;
                r_dly[k] = $urandom_range(0, 3);
                prog(k, 32'(r_op[k]), r_dat[k], 32'(r_dly[k]));
                if ($urandom_range(0, 1) == 1)
                    cfg_write(CFG_OP, ($urandom_range(0, 1) == 1)
                        ? 32'h2 : 32'($urandom_range(5, 1000)));
            end
            cfg_write(CFG_LEN, 32'(len));
            for (int c = 0; c < 200; c++)
                gp[c] = (c % 4 == 3) || ($urandom_range(0, 9) < 6);
            t = 1;
            for (int k = 0; k < len; k++) begin
                while (!gp[t]) t++;
                r_ec[k] = t;
                t = t + r_dly[k] + 1;
            end
            done_c = t;
            cfg_write(CFG_CTRL, 32'h1);
            nw = 0;
            for (int c = 1; c <= done_c + 1; c++) begin
                gpio_gnt = gp[c];
                #1;
                if (gpio_we) begin
                    if (nw < len) begin
                        check($sformatf("rnd%0d_cyc%0d", it, nw),
                              c, r_ec[nw]);
                        check($sformatf("rnd%0d_addr%0d", it, nw),
                              gpio_addr, 32'(r_op[nw]));
                        check($sformatf("rnd%0d_data%0d", it, nw),
                              gpio_wdata, r_dat[nw]);
                    end else begin
                        check($sformatf("rnd%0d_extra", it), nw + 1, len);
                    end
                    nw++;
                end
                check($sformatf("rnd%0d_done_c%0d", it, c),
                      done, c == done_c);
                tick();
            end
            check($sformatf("rnd%0d_nwrites", it), nw, len);
            check($sformatf("rnd%0d_idle", it), busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
